// File: rtl/ft_host_pkg.sv
// rtl/ft_host_pkg.sv - shared tag codes, opcodes and state encodings for the FT245 host interface
package ft_host_pkg;

    typedef enum logic [1:0] {
        TAG_CMD  = 2'd0,
        TAG_ADDR = 2'd1,
        TAG_DATA = 2'd2
    } tag_e;

    typedef enum logic [1:0] {
        BUS_IDLE,
        BUS_OE,
        BUS_READ,
        BUS_RELEASE
    } bus_state_e;

    typedef enum logic [1:0] {
        FR_HUNT,
        FR_CMD,
        FR_ADDR,
        FR_DATA
    } frame_state_e;

    localparam logic [3:0] OP_WRITE          = 4'd1;
    localparam logic [3:0] OP_READ           = 4'd2;
    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hCD;

    // A write command with a zero length still carries one data word.
    function automatic logic [23:0] write_len(input logic [23:0] n);
        return (n == 24'd0) ? 24'd1 : n;
    endfunction

endpackage

// File: rtl/ft245_word_packer.sv
// rtl/ft245_word_packer.sv - packs accepted bytes MSB-first into 32-bit words
module ft245_word_packer (
    input  logic        ftdi_clk,
    input  logic        rst,
    input  logic        i_clear,
    input  logic        i_byte_valid,
    input  logic [7:0]  i_byte,
    output logic        o_word_done,
    output logic [31:0] o_word
);

    logic [1:0]  r_cnt;
    logic [23:0] r_shift;

    always_ff @(posedge ftdi_clk) begin
        if (rst || i_clear) begin
            r_cnt   <= 2'd0;
            r_shift <= 24'd0;
        end else if (i_byte_valid) begin
            r_cnt   <= r_cnt + 2'd1;
            r_shift <= {r_shift[15:0], i_byte};
        end
    end

    assign o_word_done = i_byte_valid && (r_cnt == 2'd3);
    assign o_word      = {r_shift, i_byte};

endmodule

// File: rtl/ft245_sync_rx_deframer.sv
// rtl/ft245_sync_rx_deframer.sv - FT245 sync-FIFO read front end and CMD/ADDR/DATA deframer
// Optional idle timeout build: FT_RX_TIMEOUT_EN
module ft245_sync_rx_deframer
    import ft_host_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT,
    parameter int         FREE_W    = 6,
    parameter int         HEADROOM  = 4
`ifdef FT_RX_TIMEOUT_EN
    , parameter int       TIMEOUT_CYCLES = 1024
`endif
) (
    input  logic              ftdi_clk,
    input  logic              rst,
    input  logic [7:0]        ftdi_data_i,
    input  logic              ftdi_rde_n,
    output logic              ftdi_oe_n,
    output logic              ftdi_rd_n,
    input  logic [FREE_W-1:0] fifo_free,
    output logic              fifo_wr,
    output logic [31:0]       fifo_data,
    output logic [1:0]        fifo_tag,
    output logic              fifo_eof,
    output logic              frame_active,
    output logic              sync_err
`ifdef FT_RX_TIMEOUT_EN
    , output logic            timeout_err
`endif
);

    bus_state_e   r_bus, w_bus_nxt;
    frame_state_e r_frame, w_frame_nxt;
    logic         r_oe_n, r_rd_n, w_oe_n_d, w_rd_n_d;
    logic [23:0]  r_word_cnt, w_word_cnt_nxt;
    logic         r_fifo_wr, r_fifo_eof, r_frame_active, r_sync_err;
    logic [31:0]  r_fifo_data;
    tag_e         r_fifo_tag, w_tag;
    logic         w_room, w_byte_acc, w_pack_valid, w_word_done, w_eof, w_sync_err, w_timeout;
    logic [31:0]  w_word;

    assign w_room       = fifo_free >= FREE_W'(HEADROOM);
    assign w_byte_acc   = !r_rd_n && !ftdi_rde_n;
    assign w_pack_valid = w_byte_acc && (r_frame != FR_HUNT);

    ft245_word_packer u_packer (
        .ftdi_clk     (ftdi_clk),
        .rst          (rst),
        .i_clear      (w_timeout),
        .i_byte_valid (w_pack_valid),
        .i_byte       (ftdi_data_i),
        .o_word_done  (w_word_done),
        .o_word       (w_word)
    );

    always_ff @(posedge ftdi_clk) begin
        if (rst) begin
            r_bus  <= BUS_IDLE;
            r_oe_n <= 1'b1;
            r_rd_n <= 1'b1;
        end else begin
            r_bus  <= w_bus_nxt;
            r_oe_n <= w_oe_n_d;
            r_rd_n <= w_rd_n_d;
        end
    end

    always_comb begin
        w_bus_nxt = r_bus;
        case (r_bus)
            BUS_IDLE:    if (!ftdi_rde_n && w_room) w_bus_nxt = BUS_OE;
            BUS_OE:      w_bus_nxt = BUS_READ;
            BUS_READ:    if (ftdi_rde_n || !w_room) w_bus_nxt = BUS_RELEASE;
            BUS_RELEASE: w_bus_nxt = BUS_IDLE;
            default:     w_bus_nxt = BUS_IDLE;
        endcase
    end

    // Outputs follow the next state so the pins are registered with it.
    always_comb begin
        w_oe_n_d = !((w_bus_nxt == BUS_OE) || (w_bus_nxt == BUS_READ));
        w_rd_n_d = (w_bus_nxt != BUS_READ);
    end

    always_ff @(posedge ftdi_clk) begin
        if (rst) begin
            r_frame        <= FR_HUNT;
            r_word_cnt     <= 24'd0;
            r_fifo_wr      <= 1'b0;
            r_fifo_data    <= 32'd0;
            r_fifo_tag     <= TAG_CMD;
            r_fifo_eof     <= 1'b0;
            r_frame_active <= 1'b0;
            r_sync_err     <= 1'b0;
        end else begin
            r_frame        <= w_frame_nxt;
            r_word_cnt     <= w_word_cnt_nxt;
            r_fifo_wr      <= w_word_done;
            r_fifo_eof     <= w_eof;
            r_frame_active <= (w_frame_nxt != FR_HUNT);
            r_sync_err     <= w_sync_err;
            if (w_word_done) begin
                r_fifo_data <= w_word;
                r_fifo_tag  <= w_tag;
            end
        end
    end

    always_comb begin
        w_frame_nxt    = r_frame;
        w_word_cnt_nxt = r_word_cnt;
        case (r_frame)
            FR_HUNT: if (w_byte_acc && (ftdi_data_i == SYNC_BYTE)) w_frame_nxt = FR_CMD;
            FR_CMD: if (w_word_done) begin
                if (w_word[27:24] == OP_WRITE) begin
                    w_word_cnt_nxt = write_len(w_word[23:0]);
                    w_frame_nxt    = FR_ADDR;
                end else if (w_word[27:24] == OP_READ) begin
                    w_word_cnt_nxt = 24'd0;
                    w_frame_nxt    = FR_ADDR;
                end else begin
                    w_frame_nxt    = FR_HUNT;
                end
            end
            FR_ADDR: if (w_word_done) w_frame_nxt = (r_word_cnt == 24'd0) ? FR_HUNT : FR_DATA;
            FR_DATA: if (w_word_done) begin
                w_word_cnt_nxt = r_word_cnt - 24'd1;
                if (r_word_cnt == 24'd1) w_frame_nxt = FR_HUNT;
            end
            default: w_frame_nxt = FR_HUNT;
        endcase
        if (w_timeout) w_frame_nxt = FR_HUNT;
    end

    // A completed word that sends the frame back to HUNT is by construction the eof word.
    always_comb begin
        w_eof      = w_word_done && (w_frame_nxt == FR_HUNT);
        w_sync_err = w_byte_acc && (r_frame == FR_HUNT) && (ftdi_data_i != SYNC_BYTE);
        case (r_frame)
            FR_CMD:  w_tag = TAG_CMD;
            FR_ADDR: w_tag = TAG_ADDR;
            default: w_tag = TAG_DATA;
        endcase
    end

`ifdef FT_RX_TIMEOUT_EN
    logic [15:0] r_idle_cnt;
    logic        r_timeout_err;

    assign w_timeout = r_frame_active && !w_byte_acc && (r_idle_cnt == 16'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge ftdi_clk) begin
        if (rst || w_byte_acc || !r_frame_active || w_timeout) r_idle_cnt <= 16'd0;
        else                                                    r_idle_cnt <= r_idle_cnt + 16'd1;
        if (rst) r_timeout_err <= 1'b0;
        else     r_timeout_err <= w_timeout;
    end

    assign timeout_err = r_timeout_err;
`else
    assign w_timeout = 1'b0;
`endif

    assign ftdi_oe_n    = r_oe_n;
    assign ftdi_rd_n    = r_rd_n;
    assign fifo_wr      = r_fifo_wr;
    assign fifo_data    = r_fifo_data;
    assign fifo_tag     = r_fifo_tag;
    assign fifo_eof     = r_fifo_eof;
    assign frame_active = r_frame_active;
    assign sync_err     = r_sync_err;

endmodule

// File: tb/tb_ft245_sync_rx_deframer.sv
// tb/tb_ft245_sync_rx_deframer.sv - scoreboard bench for ft245_sync_rx_deframer
module tb_ft245_sync_rx_deframer;

    logic        ftdi_clk = 1'b0;
    logic        rst;
    logic [7:0]  ftdi_data_i;
    logic        ftdi_rde_n;
    logic        ftdi_oe_n, ftdi_rd_n;
    logic [5:0]  fifo_free;
    logic        fifo_wr, fifo_eof, frame_active, sync_err;
    logic [31:0] fifo_data;
    logic [1:0]  fifo_tag;
`ifdef FT_RX_TIMEOUT_EN
    logic        timeout_err;
`endif

    always #8 ftdi_clk = ~ftdi_clk;

    ft245_sync_rx_deframer dut (
        .ftdi_clk     (ftdi_clk),
        .rst          (rst),
        .ftdi_data_i  (ftdi_data_i),
        .ftdi_rde_n   (ftdi_rde_n),
        .ftdi_oe_n    (ftdi_oe_n),
        .ftdi_rd_n    (ftdi_rd_n),
        .fifo_free    (fifo_free),
        .fifo_wr      (fifo_wr),
        .fifo_data    (fifo_data),
        .fifo_tag     (fifo_tag),
        .fifo_eof     (fifo_eof),
        .frame_active (frame_active),
        .sync_err     (sync_err)
`ifdef FT_RX_TIMEOUT_EN
        , .timeout_err (timeout_err)
`endif
    );

    typedef struct {
        logic [31:0] d;
        logic [1:0]  t;
        logic        e;
    } exp_t;

    exp_t        exp_q[$];
    logic [7:0]  tx_q[$];
    logic [7:0]  stage_q[$];
    logic [31:0] dq[$];
    int          n_vec = 0, n_err = 0;
    int          exp_sync = 0, sync_seen = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) stage_q.push_back(w[8*i +: 8]);
    endtask

    // Builds one frame's bytes and its expected word sequence straight from the framing rules.
    task automatic send_frame(input logic [31:0] cmd, input logic [31:0] addr, input int ngarbage);
        logic [7:0]  b;
        logic [31:0] d;
        int          n;
        for (int i = 0; i < ngarbage; i++) begin
            b = 8'($urandom_range(0, 255));
            if (b == 8'hCD) b = 8'h3C;
            stage_q.push_back(b);
            exp_sync++;
        end
        stage_q.push_back(8'hCD);
        push_word(cmd);
        if (cmd[27:24] != 4'd1 && cmd[27:24] != 4'd2) begin
            exp_q.push_back('{cmd, 2'd0, 1'b1});
            return;
        end
        n = (cmd[27:24] == 4'd2) ? 0 : (cmd[23:0] == 0 ? 1 : int'(cmd[23:0]));
        exp_q.push_back('{cmd, 2'd0, 1'b0});
        push_word(addr);
        exp_q.push_back('{addr, 2'd1, n == 0});
        for (int i = 0; i < n; i++) begin
            d = (dq.size() > 0) ? dq.pop_front() : $urandom;
            push_word(d);
            exp_q.push_back('{d, 2'd2, i == n - 1});
        end
    endtask

    task automatic move_bytes(input int k);
        for (int i = 0; i < k && stage_q.size() > 0; i++) tx_q.push_back(stage_q.pop_front());
    endtask

    task automatic wait_drain(input string name);
        int t = 0;
        while ((tx_q.size() > 0 || exp_q.size() > 0) && t < 3000) begin
            @(posedge ftdi_clk);
            t++;
        end
        repeat (3) @(posedge ftdi_clk);
        #1;
        chk({name, "_drain"}, t < 3000, 1);
    endtask

    // FTDI side: a byte leaves the FIFO on each edge where rd_n and rde_n were both low.
    task automatic ftdi_drive();
        forever begin
            @(posedge ftdi_clk);
            if (!rst && !ftdi_rd_n && !ftdi_rde_n && tx_q.size() > 0) void'(tx_q.pop_front());
            #1;
            ftdi_rde_n  = (tx_q.size() == 0);
            ftdi_data_i = (tx_q.size() > 0) ? tx_q[0] : 8'h00;
        end
    endtask

    task automatic mon_out();
        exp_t e;
        forever begin
            @(negedge ftdi_clk);
            if (sync_err) sync_seen++;
            if (fifo_wr) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_write: got %h expected no write", fifo_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("word_data", fifo_data, e.d);
                    chk("word_tag", fifo_tag, e.t);
                    chk("word_eof", fifo_eof, e.e);
                end
            end
        end
    endtask

    task automatic mon_bus();
        logic       p_oe = 1'b1, p_rd = 1'b1, p_rde = 1'b1, p_rst = 1'b1;
        logic [5:0] p_free = '0;
        forever begin
            @(posedge ftdi_clk);
            if (!p_rst && !rst) begin
                if (!ftdi_rd_n && p_rd) chk("oe_before_rd", p_oe, 0);
                if (!p_rd && (p_rde || p_free < 6'd4)) chk("release_1cyc", {ftdi_rd_n, ftdi_oe_n}, 2'b11);
                if (p_oe && !ftdi_oe_n) chk("oe_start_cond", !p_rde && p_free >= 6'd4, 1);
            end
            p_oe = ftdi_oe_n; p_rd = ftdi_rd_n; p_rde = ftdi_rde_n; p_rst = rst; p_free = fifo_free;
        end
    endtask

    initial begin
        int s0, k, gap;
        logic [3:0] op;
        rst = 1'b1; ftdi_rde_n = 1'b1; ftdi_data_i = 8'h00; fifo_free = 6'd32;
        fork
            ftdi_drive();
            mon_out();
            mon_bus();
        join_none
        repeat (3) @(posedge ftdi_clk);
        #1 rst = 1'b0;
        @(negedge ftdi_clk);
        chk("rst_pins", {ftdi_oe_n, ftdi_rd_n, fifo_wr, fifo_eof, frame_active, sync_err}, 6'b110000);
        chk("rst_data", fifo_data, 0);
        chk("rst_tag", fifo_tag, 0);
        @(posedge ftdi_clk); #1;

        send_frame(32'h00000000, 0, 0);
        move_bytes(stage_q.size());
        wait_drain("ping");

        dq = {32'h11223344, 32'h55667788};
        send_frame(32'h01000002, 32'h00000100, 0);
        move_bytes(stage_q.size());
        wait_drain("write");

        send_frame(32'h02000001, 32'h01000000, 0);
        move_bytes(stage_q.size());
        wait_drain("read");

        send_frame(32'hF1000000, 32'hDEADBEEF, 0);
        move_bytes(stage_q.size());
        wait_drain("write_len0");

        dq = {32'h11223344, 32'h55667788};
        send_frame(32'h01000002, 32'h00000100, 0);
        move_bytes(6);
        for (int t = 0; t < 200 && tx_q.size() > 0; t++) @(posedge ftdi_clk);
        repeat (10) @(posedge ftdi_clk);
        #1 move_bytes(stage_q.size());
        wait_drain("pause_resume");

        send_frame(32'h01000006, 32'h00000200, 0);
        move_bytes(stage_q.size());
        repeat (8) @(posedge ftdi_clk);
        #1 fifo_free = 6'd3;
        repeat (6) @(posedge ftdi_clk);
        #1 fifo_free = 6'd4;
        wait_drain("backpressure");
        fifo_free = 6'd32;

        s0 = sync_seen;
        stage_q.push_back(8'hAA);
        stage_q.push_back(8'h55);
        exp_sync += 2;
        send_frame(32'h00000000, 0, 0);
        move_bytes(stage_q.size());
        wait_drain("garbage_ping");
        chk("sync_err_pulses", sync_seen - s0, 2);

        for (int f = 0; f < 25; f++) begin
            k  = $urandom_range(0, 2);
            op = (k == 0) ? 4'd1 : (k == 1) ? 4'd2 : 4'($urandom_range(3, 15));
            send_frame({4'($urandom), op, (op == 4'd1) ? 24'($urandom_range(0, 4)) : 24'($urandom)},
                       $urandom, $urandom_range(0, 3));
            while (stage_q.size() > 0) begin
                move_bytes($urandom_range(1, 8));
                gap = $urandom_range(0, 12);
                repeat (gap) begin
                    @(posedge ftdi_clk);
                    #1 fifo_free = ($urandom_range(0, 4) == 0) ? 6'($urandom_range(0, 3))
                                                               : 6'($urandom_range(4, 63));
                end
            end
            fifo_free = 6'd32;
            wait_drain("random");
        end

        stage_q = {8'hCD, 8'h01, 8'h00};
        move_bytes(3);
        for (int t = 0; t < 200 && tx_q.size() > 0; t++) @(posedge ftdi_clk);
        repeat (3) @(posedge ftdi_clk);
        #1 chk("active_mid_frame", frame_active, 1);
        rst = 1'b1;
        repeat (2) @(posedge ftdi_clk);
        #1 rst = 1'b0;
        chk("active_after_rst", frame_active, 0);
        send_frame(32'h03ABCDEF, 0, 0);
        move_bytes(stage_q.size());
        wait_drain("post_reset_ping");

        chk("sync_err_total", sync_seen, exp_sync);
        chk("idle_frame_active", frame_active, 0);
        chk("exp_queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
